// File: rtl/cp0_regfile_if.sv
// rtl/cp0_regfile_if.sv - commit/read bus between the pipeline and the CP0 register file
interface cp0_regfile_if #(
    parameter int NUM_HW_INT = 6
);
    logic [NUM_HW_INT-1:0] ext_int;
    logic [4:0]            rd_addr;
    logic [31:0]           rd_data;
    logic                  wr_en;
    logic [4:0]            wr_addr;
    logic [31:0]           wr_data;
    logic                  exc_valid;
    logic [4:0]            exc_code;
    logic [31:0]           exc_pc;
    logic                  exc_bd;
    logic                  exc_badvaddr_valid;
    logic [31:0]           exc_badvaddr;
    logic                  eret;
    logic [31:0]           epc;
    logic                  status_exl;
    logic                  timer_int;
    logic                  int_pending;

    modport master (
        output ext_int, rd_addr, wr_en, wr_addr, wr_data,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr_valid, exc_badvaddr, eret,
        input  rd_data, epc, status_exl, timer_int, int_pending
    );

    modport slave (
        input  ext_int, rd_addr, wr_en, wr_addr, wr_data,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr_valid, exc_badvaddr, eret,
        output rd_data, epc, status_exl, timer_int, int_pending
    );
endinterface

// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - MIPS CP0 register file: masked MTC0, Count/Compare timer, interrupts, exception/ERET commit
module cp0_regfile #(
    parameter int NUM_HW_INT   = 6,
    parameter int COUNT_DIV    = 2,
    parameter int HAS_ERROREPC = 1
) (
    input  logic          clk,
    input  logic          resetn,
    cp0_regfile_if.slave  bus
);
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_ERROREPC = 5'd30;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam int             PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]   badvaddr_q, badvaddr_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [31:0]   status_q, status_d;
    logic [31:0]   cause_q, cause_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   errorepc_q, errorepc_d;
    logic [PW-1:0] presc_q, presc_d;

    logic       sw_wr;
    logic       count_inc;
    logic       ti_d;
    logic [5:0] ip_hw;

    // Exception and ERET outrank MTC0; the dropped write must not touch Count either.
    assign sw_wr = bus.wr_en & ~bus.exc_valid & ~bus.eret;

    always_comb begin
        badvaddr_d = badvaddr_q;
        count_d    = count_q;
        compare_d  = compare_q;
        status_d   = status_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        errorepc_d = errorepc_q;
        presc_d    = presc_q;
        count_inc  = 1'b0;
        ti_d       = cause_q[30];
        ip_hw      = '0;

        if (sw_wr && bus.wr_addr == REG_COUNT) begin
            count_d = bus.wr_data;
            presc_d = '0;
        end else if (presc_q == PRESC_MAX) begin
            presc_d   = '0;
            count_d   = count_q + 32'd1;
            count_inc = 1'b1;
        end else begin
            presc_d = presc_q + 1'b1;
        end

        if (sw_wr && bus.wr_addr == REG_COMPARE) begin
            ti_d = 1'b0;
        end else if (count_inc && count_d == compare_q) begin
            ti_d = 1'b1;
        end

        if (bus.exc_valid) begin
            if (!status_q[1]) begin
                epc_d       = bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                cause_d[31] = bus.exc_bd;
            end
            cause_d[6:2] = bus.exc_code;
            status_d[1]  = 1'b1;
            if (bus.exc_badvaddr_valid) begin
                badvaddr_d = bus.exc_badvaddr;
            end
        end else if (bus.eret) begin
            status_d[1] = 1'b0;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                REG_COMPARE:  compare_d = bus.wr_data;
                REG_STATUS:   status_d  = (status_q & ~STATUS_WMASK) | (bus.wr_data & STATUS_WMASK);
                REG_CAUSE:    cause_d   = (cause_q & ~CAUSE_WMASK) | (bus.wr_data & CAUSE_WMASK);
                REG_EPC:      epc_d     = bus.wr_data;
                REG_ERROREPC: if (HAS_ERROREPC != 0) errorepc_d = bus.wr_data;
                default: ;
            endcase
        end

        // IP[7] is shared between the last hardware line and the timer.
        for (int i = 0; i < NUM_HW_INT; i++) begin
            ip_hw[i] = bus.ext_int[i];
        end
        ip_hw[5]       = ip_hw[5] | ti_d;
        cause_d[30]    = ti_d;
        cause_d[15:10] = ip_hw;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RESET;
            cause_q    <= '0;
            epc_q      <= '0;
            errorepc_q <= '0;
            presc_q    <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            errorepc_q <= errorepc_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            REG_BADVADDR: bus.rd_data = badvaddr_q;
            REG_COUNT:    bus.rd_data = count_q;
            REG_COMPARE:  bus.rd_data = compare_q;
            REG_STATUS:   bus.rd_data = status_q;
            REG_CAUSE:    bus.rd_data = cause_q;
            REG_EPC:      bus.rd_data = epc_q;
            REG_ERROREPC: bus.rd_data = (HAS_ERROREPC != 0) ? errorepc_q : 32'd0;
            default:      bus.rd_data = '0;
        endcase
    end

    assign bus.epc         = epc_q;
    assign bus.status_exl  = status_q[1];
    assign bus.timer_int   = cause_q[30];
    assign bus.int_pending = status_q[0] & ~status_q[1] & (|(cause_q[15:8] & status_q[15:8]));
endmodule

// File: tb/tb_cp0_regfile.sv
// tb/tb_cp0_regfile.sv - scoreboard bench for cp0_regfile against a field-level CP0 model
module tb_cp0_regfile;
    localparam int NHW = 6;
    localparam int DIV = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cp0_regfile_if #(.NUM_HW_INT(NHW)) bus ();

    cp0_regfile #(.NUM_HW_INT(NHW), .COUNT_DIV(DIV), .HAS_ERROREPC(1)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic [31:0] epc;
        logic        exl;
        logic        ti;
        logic        ip;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model kept as architectural fields rather than packed registers.
    logic [31:0] m_bad, m_count, m_cmp, m_epc, m_eepc;
    logic        m_bev, m_exl, m_ie, m_bd, m_ti;
    logic [7:0]  m_im, m_ip;
    logic [4:0]  m_exc;
    int          m_presc;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_bad;
            5'd9:  return m_count;
            5'd11: return m_cmp;
            5'd12: return {9'b0, m_bev, 6'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13: return {m_bd, m_ti, 14'b0, m_ip, 1'b0, m_exc, 2'b0};
            5'd14: return m_epc;
            5'd30: return m_eepc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_bad = 0; m_count = 0; m_cmp = 0; m_epc = 0; m_eepc = 0;
        m_bev = 1; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0;
        m_im = 0; m_ip = 0; m_exc = 0; m_presc = 0;
    endtask

    task automatic m_step();
        logic sw;
        logic inc;
        sw  = bus.wr_en && !bus.exc_valid && !bus.eret;
        inc = 1'b0;
        if (sw && bus.wr_addr == 5'd9) begin
            m_count = bus.wr_data;
            m_presc = 0;
        end else if (m_presc == DIV - 1) begin
            m_presc = 0;
            m_count = m_count + 1;
            inc = 1'b1;
        end else begin
            m_presc = m_presc + 1;
        end
        if (sw && bus.wr_addr == 5'd11) m_ti = 1'b0;
        else if (inc && m_count == m_cmp) m_ti = 1'b1;

        if (bus.exc_valid) begin
            if (!m_exl) begin
                m_epc = bus.exc_bd ? bus.exc_pc - 4 : bus.exc_pc;
                m_bd  = bus.exc_bd;
            end
            m_exc = bus.exc_code;
            m_exl = 1'b1;
            if (bus.exc_badvaddr_valid) m_bad = bus.exc_badvaddr;
        end else if (bus.eret) begin
            m_exl = 1'b0;
        end else if (bus.wr_en) begin
            case (bus.wr_addr)
                5'd11: m_cmp = bus.wr_data;
                5'd12: begin m_im = bus.wr_data[15:8]; m_exl = bus.wr_data[1]; m_ie = bus.wr_data[0]; end
                5'd13: m_ip[1:0] = bus.wr_data[9:8];
                5'd14: m_epc = bus.wr_data;
                5'd30: m_eepc = bus.wr_data;
                default: ;
            endcase
        end
        for (int i = 2; i < 8; i++) m_ip[i] = 1'b0;
        for (int i = 0; i < NHW; i++) m_ip[2+i] = bus.ext_int[i];
        m_ip[7] = m_ip[7] | m_ti;
    endtask

    task automatic push_exp();
        exp_t e;
        e.rd  = m_read(bus.rd_addr);
        e.epc = m_epc;
        e.exl = m_exl;
        e.ti  = m_ti;
        e.ip  = m_ie && !m_exl && ((m_ip & m_im) != 8'd0);
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data",     bus.rd_data,            e.rd);
                chk("epc",         bus.epc,                e.epc);
                chk("status_exl",  32'(bus.status_exl),    32'(e.exl));
                chk("timer_int",   32'(bus.timer_int),     32'(e.ti));
                chk("int_pending", 32'(bus.int_pending),   32'(e.ip));
            end
        end
    end

    task automatic idle_inputs();
        bus.wr_en = 0; bus.exc_valid = 0; bus.eret = 0; bus.exc_badvaddr_valid = 0;
    endtask

    task automatic tick();
        push_exp();
        m_step();
    endtask

    task automatic cyc_rd(input logic [4:0] ra);
        @(negedge clk); idle_inputs(); bus.rd_addr = ra; tick();
    endtask

    task automatic cyc_wr(input logic [4:0] wa, input logic [31:0] d, input logic [4:0] ra);
        @(negedge clk); idle_inputs();
        bus.wr_en = 1; bus.wr_addr = wa; bus.wr_data = d; bus.rd_addr = ra; tick();
    endtask

    task automatic cyc_exc(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                           input logic bvav, input logic [31:0] bva, input logic [4:0] ra, input logic also_wr);
        @(negedge clk); idle_inputs();
        bus.exc_valid = 1; bus.exc_pc = pc; bus.exc_bd = bd; bus.exc_code = code;
        bus.exc_badvaddr_valid = bvav; bus.exc_badvaddr = bva; bus.rd_addr = ra;
        bus.wr_en = also_wr; bus.wr_addr = 5'd14; bus.wr_data = 32'hDEAD_BEEF;
        tick();
    endtask

    task automatic cyc_eret(input logic [4:0] ra, input logic also_wr);
        @(negedge clk); idle_inputs();
        bus.eret = 1; bus.rd_addr = ra;
        bus.wr_en = also_wr; bus.wr_addr = 5'd14; bus.wr_data = 32'h0BAD_F00D;
        tick();
    endtask

    // Reset asserted and released between rising edges; the check lands while resetn is low.
    task automatic rst_pulse(input logic [4:0] ra);
        @(negedge clk); idle_inputs(); bus.rd_addr = ra;
        resetn = 0;
        m_reset();
        push_exp();
        #3;
        resetn = 1;
        m_step();
    endtask

    function automatic logic [4:0] pick_addr();
        logic [4:0] r;
        case ($urandom % 9)
            0: r = 5'd8;  1: r = 5'd9;  2: r = 5'd11; 3: r = 5'd12;
            4: r = 5'd13; 5: r = 5'd14; 6: r = 5'd30;
            default: r = 5'($urandom);
        endcase
        return r;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d expected 0", q.size());
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin : driver
        bus.ext_int = '0; bus.rd_addr = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.exc_valid = 0; bus.exc_code = 0; bus.exc_pc = 0; bus.exc_bd = 0;
        bus.exc_badvaddr_valid = 0; bus.exc_badvaddr = 0; bus.eret = 0;
        m_reset();

        rst_pulse(5'd12);
        cyc_rd(5'd12);
        cyc_rd(5'd13);
        for (int i = 0; i < 10; i++) cyc_rd(5'd9);

        cyc_wr(5'd12, 32'hFFFF_FFFF, 5'd12);
        cyc_rd(5'd12);
        cyc_wr(5'd13, 32'hFFFF_FFFF, 5'd13);
        cyc_rd(5'd13);
        cyc_wr(5'd8, 32'h0000_1234, 5'd8);
        cyc_rd(5'd8);
        cyc_rd(5'd5);

        cyc_wr(5'd13, 32'h0, 5'd13);
        cyc_wr(5'd12, 32'h0000_8001, 5'd12);
        cyc_wr(5'd9, 32'h0, 5'd9);
        cyc_wr(5'd11, 32'h3, 5'd13);
        for (int i = 0; i < 8; i++) cyc_rd(5'd13);
        cyc_wr(5'd11, 32'h3, 5'd13);
        cyc_wr(5'd9, 32'h1, 5'd9);
        cyc_rd(5'd9);
        cyc_rd(5'd9);
        cyc_rd(5'd9);
        cyc_wr(5'd11, 32'h3, 5'd13);
        for (int i = 0; i < 4; i++) cyc_rd(5'd13);

        cyc_wr(5'd11, 32'h8000_0000, 5'd12);
        cyc_wr(5'd12, 32'h0, 5'd12);
        cyc_exc(32'hBFC0_0104, 1'b1, 5'd4, 1'b1, 32'h0000_1233, 5'd14, 1'b0);
        cyc_rd(5'd14);
        cyc_rd(5'd13);
        cyc_rd(5'd8);
        cyc_exc(32'h8000_0200, 1'b0, 5'd5, 1'b0, 32'hFFFF_0000, 5'd13, 1'b0);
        cyc_rd(5'd14);
        cyc_rd(5'd13);
        cyc_eret(5'd12, 1'b0);
        cyc_rd(5'd12);

        cyc_wr(5'd12, 32'h0000_0401, 5'd12);
        @(negedge clk); idle_inputs(); bus.ext_int = NHW'(1); bus.rd_addr = 5'd13; tick();
        cyc_rd(5'd13);
        cyc_wr(5'd12, 32'h0000_0403, 5'd12);
        cyc_rd(5'd13);
        @(negedge clk); idle_inputs(); bus.ext_int = '0; bus.rd_addr = 5'd13; tick();

        cyc_exc(32'h0000_4000, 1'b0, 5'd8, 1'b0, 32'h0, 5'd14, 1'b1);
        cyc_rd(5'd14);
        cyc_eret(5'd14, 1'b1);
        cyc_rd(5'd14);
        cyc_rd(5'd12);

        cyc_wr(5'd9, 32'h0000_0020, 5'd9);
        cyc_rd(5'd9);
        rst_pulse(5'd9);
        cyc_rd(5'd9);

        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            idle_inputs();
            if ($urandom % 500 == 0) begin
                bus.rd_addr = pick_addr();
                resetn = 0;
                m_reset();
                push_exp();
                #3;
                resetn = 1;
                m_step();
            end else begin
                bus.rd_addr = pick_addr();
                if ($urandom % 6 == 0) bus.ext_int = NHW'($urandom);
                bus.wr_en   = ($urandom % 3 == 0);
                bus.wr_addr = pick_addr();
                bus.wr_data = $urandom;
                if (bus.wr_addr == 5'd11) bus.wr_data = m_count + $urandom_range(0, 4);
                if (bus.wr_addr == 5'd9 && $urandom % 2 == 0) bus.wr_data = m_cmp - $urandom_range(0, 3);
                bus.exc_valid = ($urandom % 8 == 0);
                bus.eret      = ($urandom % 8 == 0);
                bus.exc_code  = 5'($urandom);
                bus.exc_pc    = $urandom;
                bus.exc_bd    = 1'($urandom);
                bus.exc_badvaddr_valid = 1'($urandom);
                bus.exc_badvaddr = $urandom;
                tick();
            end
        end

        @(negedge clk); idle_inputs();
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
